// File: rtl/mem_arb_4_if.sv
// Bus bundle between four cores, the arbiter and the shared memory port.
// grant_cnt exists only when MEM_ARB_STATS_EN is defined.
interface mem_arb_4_if;
  logic [0:3]  req;
  logic [0:3]  wr_en;
  logic [0:31] addr0;
  logic [0:31] addr1;
  logic [0:31] addr2;
  logic [0:31] addr3;
  logic [0:63] wdata0;
  logic [0:63] wdata1;
  logic [0:63] wdata2;
  logic [0:63] wdata3;
  logic [0:3]  gnt;
  logic [0:3]  rvalid;
  logic [0:63] rdata;
  logic        mem_en;
  logic        mem_wr_en;
  logic [0:31] mem_addr;
  logic [0:63] mem_dout;
  logic [0:63] mem_din;
`ifdef MEM_ARB_STATS_EN
  logic [0:63] grant_cnt;

  modport slave (
    input  req, wr_en, addr0, addr1, addr2, addr3,
    input  wdata0, wdata1, wdata2, wdata3, mem_din,
    output gnt, rvalid, rdata, mem_en, mem_wr_en, mem_addr, mem_dout, grant_cnt
  );

  modport master (
    output req, wr_en, addr0, addr1, addr2, addr3,
    output wdata0, wdata1, wdata2, wdata3, mem_din,
    input  gnt, rvalid, rdata, mem_en, mem_wr_en, mem_addr, mem_dout, grant_cnt
  );
`else
  modport slave (
    input  req, wr_en, addr0, addr1, addr2, addr3,
    input  wdata0, wdata1, wdata2, wdata3, mem_din,
    output gnt, rvalid, rdata, mem_en, mem_wr_en, mem_addr, mem_dout
  );

  modport master (
    output req, wr_en, addr0, addr1, addr2, addr3,
    output wdata0, wdata1, wdata2, wdata3, mem_din,
    input  gnt, rvalid, rdata, mem_en, mem_wr_en, mem_addr, mem_dout
  );
`endif
endinterface

// File: rtl/mem_arb_4.sv
// Four-core round-robin arbiter for one shared single-port memory.
// Optional per-core grant counters are enabled with MEM_ARB_STATS_EN.
module mem_arb_4 (
  input  logic        clk,
  input  logic        reset,
  mem_arb_4_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  lastGrant_q, lastGrant_d;
  logic [1:0]  winner_q, winner_d;
  logic [0:31] addr_q, addr_d;
  logic [0:63] wdata_q, wdata_d;
  logic        wrEn_q, wrEn_d;

  logic [1:0]  pick;
  logic        found;
  logic [0:31] selAddr;
  logic [0:63] selWdata;

  logic [0:3]  gnt;
  logic [0:3]  rvalid;
  logic [0:63] rdata;
  logic        memEn;
  logic        memWrEn;
  logic [0:31] memAddr;
  logic [0:63] memDout;

  // Search starts just after the last granted core and wraps in 2-bit arithmetic.
  always_comb begin
    pick  = lastGrant_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && bus.req[lastGrant_q + 2'(k)]) begin
        pick  = lastGrant_q + 2'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    selAddr  = bus.addr0;
    selWdata = bus.wdata0;
    case (pick)
      2'd0: begin selAddr = bus.addr0; selWdata = bus.wdata0; end
      2'd1: begin selAddr = bus.addr1; selWdata = bus.wdata1; end
      2'd2: begin selAddr = bus.addr2; selWdata = bus.wdata2; end
      default: begin selAddr = bus.addr3; selWdata = bus.wdata3; end
    endcase
  end

  // last grant is recorded only in ACCESS, so a reset there forgets the aborted core.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    winner_d    = winner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wrEn_d      = wrEn_q;
    gnt         = '0;
    rvalid      = '0;
    rdata       = '0;
    memEn       = 1'b0;
    memWrEn     = 1'b0;
    memAddr     = '0;
    memDout     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = ACCESS;
          winner_d = pick;
          addr_d   = selAddr;
          wdata_d  = selWdata;
          wrEn_d   = bus.wr_en[pick];
        end
      end
      ACCESS: begin
        memEn         = 1'b1;
        memWrEn       = wrEn_q;
        memAddr       = addr_q;
        memDout       = wdata_q;
        gnt[winner_q] = 1'b1;
        lastGrant_d   = winner_q;
        state_d       = wrEn_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        rvalid[winner_q] = 1'b1;
        rdata            = bus.mem_din;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      lastGrant_q <= 2'd3;
      winner_q    <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wrEn_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      winner_q    <= winner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wrEn_q      <= wrEn_d;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.rvalid    = rvalid;
  assign bus.rdata     = rdata;
  assign bus.mem_en    = memEn;
  assign bus.mem_wr_en = memWrEn;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_dout  = memDout;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] grantCnt_q [4];

  // Counters saturate rather than wrap so a long run never reports a small count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) grantCnt_q[i] <= '0;
    end else if (state_q == ACCESS && grantCnt_q[winner_q] != 16'hFFFF) begin
      grantCnt_q[winner_q] <= grantCnt_q[winner_q] + 16'd1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : gCnt
    assign bus.grant_cnt[16*g +: 16] = grantCnt_q[g];
  end
`endif

endmodule

// File: tb/tb_mem_arb_4.sv
// Directed bench for mem_arb_4: vector table of single transactions plus
// hand-written fairness, withdrawn-request, reset-abort and stats sequences.
module tb_mem_arb_4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mem_arb_4_if bus();

  mem_arb_4 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A0 = 32'h40, A1 = 32'h50, A2 = 32'h10, A3 = 32'h20;
  localparam logic [63:0] W0 = 64'hA0A0, W1 = 64'hB1B1, W2 = 64'hC2C2, W3 = 64'h1234;

  // reqv/wrv/expGnt use the port ordering: leftmost literal bit is core 0.
  typedef struct {
    logic [0:3]  reqv;
    logic [0:3]  wrv;
    logic [63:0] din;
    logic [0:3]  expGnt;
    logic        expWr;
    logic [31:0] expAddr;
    logic [63:0] expDout;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [0:3] r, input logic [0:3] w);
    bus.req   = r;
    bus.wr_en = w;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " gnt"}, 64'(bus.gnt), 64'h0);
    checkOutput({tag, " rvalid"}, 64'(bus.rvalid), 64'h0);
    checkOutput({tag, " rdata"}, 64'(bus.rdata), 64'h0);
    checkOutput({tag, " mem_en"}, 64'(bus.mem_en), 64'h0);
    checkOutput({tag, " mem_wr_en"}, 64'(bus.mem_wr_en), 64'h0);
    checkOutput({tag, " mem_addr"}, 64'(bus.mem_addr), 64'h0);
    checkOutput({tag, " mem_dout"}, 64'(bus.mem_dout), 64'h0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Entered at a negedge with the DUT in IDLE; leaves at a negedge in IDLE.
  task automatic runVector(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    applyStimulus(v.reqv, v.wrv);
    bus.mem_din = v.din;
    @(negedge clk);
    checkOutput({tag, " gnt"}, 64'(bus.gnt), 64'(v.expGnt));
    checkOutput({tag, " mem_en"}, 64'(bus.mem_en), 64'h1);
    checkOutput({tag, " mem_wr_en"}, 64'(bus.mem_wr_en), 64'(v.expWr));
    checkOutput({tag, " mem_addr"}, 64'(bus.mem_addr), 64'(v.expAddr));
    checkOutput({tag, " mem_dout"}, bus.mem_dout, v.expDout);
    checkOutput({tag, " rvalid in access"}, 64'(bus.rvalid), 64'h0);
    applyStimulus(4'b0000, 4'b0000);
    if (!v.expWr) begin
      @(negedge clk);
      checkOutput({tag, " rvalid"}, 64'(bus.rvalid), 64'(v.expGnt));
      checkOutput({tag, " rdata"}, bus.rdata, v.din);
      checkOutput({tag, " gnt in rdwait"}, 64'(bus.gnt), 64'h0);
      checkOutput({tag, " mem_en in rdwait"}, 64'(bus.mem_en), 64'h0);
    end
    @(negedge clk);
    checkIdle({tag, " idle"});
  endtask

  initial begin
    logic [0:3] e;
    vecs[0] = '{4'b0010, 4'b0000, 64'hA5,               4'b0010, 1'b0, A2, W2};
    vecs[1] = '{4'b0001, 4'b0001, 64'h0,                4'b0001, 1'b1, A3, W3};
    vecs[2] = '{4'b1111, 4'b1111, 64'h0,                4'b1000, 1'b1, A0, W0};
    vecs[3] = '{4'b1111, 4'b1111, 64'h0,                4'b0100, 1'b1, A1, W1};
    vecs[4] = '{4'b1001, 4'b1111, 64'h0,                4'b0001, 1'b1, A3, W3};
    vecs[5] = '{4'b1001, 4'b1111, 64'h0,                4'b1000, 1'b1, A0, W0};
    vecs[6] = '{4'b0110, 4'b0000, 64'hDEADBEEF,         4'b0100, 1'b0, A1, W1};
    vecs[7] = '{4'b1111, 4'b1010, 64'h0,                4'b0010, 1'b1, A2, W2};
    vecs[8] = '{4'b1100, 4'b0000, 64'h0123456789ABCDEF, 4'b1000, 1'b0, A0, W0};

    bus.addr0 = A0; bus.addr1 = A1; bus.addr2 = A2; bus.addr3 = A3;
    bus.wdata0 = W0; bus.wdata1 = W1; bus.wdata2 = W2; bus.wdata3 = W3;
    bus.mem_din = '0;
    applyStimulus(4'b0000, 4'b0000);

    resetDut();
    checkIdle("reset");

    for (int i = 0; i < 9; i++) runVector(i, vecs[i]);

    // A request pulse that falls before the sampling edge must not be served.
    #1 applyStimulus(4'b1000, 4'b1000);
    #2 applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("withdrawn req gnt", 64'(bus.gnt), 64'h0);
    checkOutput("withdrawn req mem_en", 64'(bus.mem_en), 64'h0);

    // Fairness: all cores writing continuously, one grant every two cycles.
    resetDut();
    applyStimulus(4'b1111, 4'b1111);
    for (int g = 0; g < 10; g++) begin
      @(negedge clk);
      e = '0;
      if (g % 2 == 0) e[(g / 2) % 4] = 1'b1;
      checkOutput($sformatf("fair cycle%0d gnt", g), 64'(bus.gnt), 64'(e));
    end
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);

    // Reset in the ACCESS cycle of a read aborts it and restores core 0 priority.
    resetDut();
    applyStimulus(4'b0100, 4'b0000);
    @(negedge clk);
    checkOutput("abort access gnt", 64'(bus.gnt), 64'(4'b0100));
    reset = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkIdle("abort after reset");
    @(negedge clk);
    checkOutput("abort no rvalid", 64'(bus.rvalid), 64'h0);
    reset = 1'b1;
    applyStimulus(4'b1111, 4'b1111);
    @(negedge clk);
    checkOutput("abort next gnt", 64'(bus.gnt), 64'(4'b1000));
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);

`ifdef MEM_ARB_STATS_EN
    resetDut();
    checkOutput("stats after reset", bus.grant_cnt, 64'h0);
    applyStimulus(4'b0010, 4'b0010);
    for (int g = 0; g < 6; g++) @(negedge clk);
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("stats core2", 64'(bus.grant_cnt[32:47]), 64'd3);
    checkOutput("stats others", {bus.grant_cnt[0:31], bus.grant_cnt[48:63]}, 64'h0);
    force dut.grantCnt_q[2] = 16'hFFFF;
    @(negedge clk);
    release dut.grantCnt_q[2];
    applyStimulus(4'b0010, 4'b0010);
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("stats saturate", 64'(bus.grant_cnt[32:47]), 64'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
